// File: rtl/audio_cfg_i2c.sv
// audio_cfg_i2c: loads the WM8731 register table over the 2-wire control bus.
// Optional macro ACK_RETRY_EN: a NACKed word is retried up to MAX_RETRY times.
module audio_cfg_i2c #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned I2C_FREQ   = 100_000,
    parameter logic [6:0]  DEV_ADDR   = 7'h1A,
    parameter bit          AUTO_START = 1'b1,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    output logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] reg_idx
);
    localparam int unsigned QDIV  = CLK_FREQ / (4 * I2C_FREQ);
    localparam int unsigned DIV_W = (QDIV > 1) ? $clog2(QDIV) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ACK, S_HI, S_LO, S_STOP, S_GAP, S_DONE, S_ERR
    } state_t;

    function automatic logic [15:0] table_word(input logic [3:0] idx);
        case (idx)
            4'd0:    table_word = 16'h1E00;
            4'd1:    table_word = 16'h0C00;
            4'd2:    table_word = 16'h0812;
            4'd3:    table_word = 16'h0A00;
            4'd4:    table_word = 16'h0E0A;
            4'd5:    table_word = 16'h1000;
            4'd6:    table_word = 16'h0479;
            4'd7:    table_word = 16'h0679;
            4'd8:    table_word = 16'h1201;
            default: table_word = 16'h0000;
        endcase
    endfunction

    function automatic logic [7:0] byte_for(input logic [1:0] sel, input logic [3:0] idx);
        logic [15:0] w;
        w = table_word(idx);
        case (sel)
            2'd0:    byte_for = {DEV_ADDR, 1'b0};
            2'd1:    byte_for = w[15:8];
            2'd2:    byte_for = w[7:0];
            default: byte_for = 8'h00;
        endcase
    endfunction

    state_t           state_r, state_s;
    logic [DIV_W-1:0] div_r, div_s;
    logic [1:0]       phase_r, phase_s;
    logic [2:0]       bit_cnt_r, bit_cnt_s;
    logic [1:0]       byte_sel_r, byte_sel_s;
    logic [3:0]       idx_r, idx_s;
    logic             nack_r, nack_s;
    logic             done_r, done_s;
    logic             error_r, error_s;
    logic             auto_r, auto_s;
    logic             scl_r, scl_s;
    logic             sda_low_r, sda_low_s;
    logic             busy_r, busy_s;
    logic             tick_s;
    logic [7:0]       cur_byte_s;
`ifdef ACK_RETRY_EN
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RETRY_W-1:0] retry_r, retry_s;
`endif

    // State register and registered bus/status outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r    <= S_IDLE;
            div_r      <= '0;
            phase_r    <= 2'd0;
            bit_cnt_r  <= 3'd0;
            byte_sel_r <= 2'd0;
            idx_r      <= 4'd0;
            nack_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            auto_r     <= AUTO_START;
            scl_r      <= 1'b1;
            sda_low_r  <= 1'b0;
            busy_r     <= 1'b0;
`ifdef ACK_RETRY_EN
            retry_r    <= '0;
`endif
        end else begin
            state_r    <= state_s;
            div_r      <= div_s;
            phase_r    <= phase_s;
            bit_cnt_r  <= bit_cnt_s;
            byte_sel_r <= byte_sel_s;
            idx_r      <= idx_s;
            nack_r     <= nack_s;
            done_r     <= done_s;
            error_r    <= error_s;
            auto_r     <= auto_s;
            scl_r      <= scl_s;
            sda_low_r  <= sda_low_s;
            busy_r     <= busy_s;
`ifdef ACK_RETRY_EN
            retry_r    <= retry_s;
`endif
        end
    end

    // Next-state logic; bus states advance one quarter-bit per divider tick.
    always_comb begin
        state_s    = state_r;
        div_s      = '0;
        phase_s    = phase_r;
        bit_cnt_s  = bit_cnt_r;
        byte_sel_s = byte_sel_r;
        idx_s      = idx_r;
        nack_s     = nack_r;
        done_s     = done_r;
        error_s    = error_r;
        auto_s     = auto_r;
`ifdef ACK_RETRY_EN
        retry_s    = retry_r;
`endif
        tick_s     = (div_r == DIV_W'(QDIV - 1));
        case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
                if (start || (auto_r && (state_r == S_IDLE))) begin
                    state_s = S_START;
                    auto_s  = 1'b0;
                    idx_s   = 4'd0;
                    phase_s = 2'd0;
                    nack_s  = 1'b0;
                    done_s  = 1'b0;
                    error_s = 1'b0;
`ifdef ACK_RETRY_EN
                    retry_s = '0;
`endif
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                div_s = tick_s ? '0 : div_r + DIV_W'(1);
                if (tick_s) begin
                    phase_s = phase_r + 2'd1;
                    if ((state_r == S_ACK) && (phase_r == 2'd2)) begin
                        nack_s = I2C_SDAT;
                    end else begin
                        nack_s = nack_r;
                    end
                    if (phase_r == 2'd3) begin
                        case (state_r)
                            S_START: begin
                                state_s    = S_ADDR;
                                byte_sel_s = 2'd0;
                                bit_cnt_s  = 3'd0;
                            end
                            S_ADDR, S_HI, S_LO: begin
                                if (bit_cnt_r == 3'd7) begin
                                    state_s   = S_ACK;
                                    bit_cnt_s = 3'd0;
                                end else begin
                                    bit_cnt_s = bit_cnt_r + 3'd1;
                                end
                            end
                            S_ACK: begin
                                if (nack_r || (byte_sel_r == 2'd2)) begin
                                    state_s = S_STOP;
                                end else if (byte_sel_r == 2'd0) begin
                                    state_s    = S_HI;
                                    byte_sel_s = 2'd1;
                                end else begin
                                    state_s    = S_LO;
                                    byte_sel_s = 2'd2;
                                end
                            end
                            S_STOP: state_s = S_GAP;
                            S_GAP: begin
                                if (nack_r) begin
`ifdef ACK_RETRY_EN
                                    if (retry_r < RETRY_W'(MAX_RETRY)) begin
                                        retry_s = retry_r + RETRY_W'(1);
                                        nack_s  = 1'b0;
                                        state_s = S_START;
                                    end else begin
                                        state_s = S_ERR;
                                        error_s = 1'b1;
                                    end
`else
                                    state_s = S_ERR;
                                    error_s = 1'b1;
`endif
                                end else if (idx_r == 4'd8) begin
                                    state_s = S_DONE;
                                    done_s  = 1'b1;
                                end else begin
                                    idx_s   = idx_r + 4'd1;
                                    state_s = S_START;
`ifdef ACK_RETRY_EN
                                    retry_s = '0;
`endif
                                end
                            end
                            default: state_s = S_IDLE;
                        endcase
                    end else begin
                        state_s = state_r;
                    end
                end else begin
                    phase_s = phase_r;
                end
            end
        endcase
    end

    // Bus levels follow the next state so SCL and SDA always change together.
    always_comb begin
        scl_s      = 1'b1;
        sda_low_s  = 1'b0;
        cur_byte_s = byte_for(byte_sel_s, idx_s);
        busy_s     = (state_s != S_IDLE) && (state_s != S_DONE) && (state_s != S_ERR);
        case (state_s)
            S_START: begin
                scl_s     = (phase_s != 2'd3);
                sda_low_s = phase_s[1];
            end
            S_ADDR, S_HI, S_LO: begin
                scl_s     = ^phase_s;
                sda_low_s = ~cur_byte_s[3'd7 - bit_cnt_s];
            end
            S_ACK: begin
                scl_s     = ^phase_s;
                sda_low_s = 1'b0;
            end
            S_STOP: begin
                scl_s     = (phase_s != 2'd0);
                sda_low_s = ~phase_s[1];
            end
            default: begin
                scl_s     = 1'b1;
                sda_low_s = 1'b0;
            end
        endcase
    end

    assign I2C_SCLK = scl_r;
    assign I2C_SDAT = sda_low_r ? 1'b0 : 1'bz;
    assign busy     = busy_r;
    assign done     = done_r;
    assign error    = error_r;
    assign reg_idx  = idx_r;

endmodule
